// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the memory initiator slice.
//   mem_op_e   : command/request opcode (load/store)
//   mem_tag_t  : per-request bookkeeping tag {op, rd} kept until the response returns
//   TAG_W      : packed width of mem_tag_t, used to size the tag FIFO
//   needs_writeback() : true for tags whose response must be written to the regfile
package mem_initiator_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    MEM_OP_LOAD  = 1'b0,
    MEM_OP_STORE = 1'b1
  } mem_op_e;

  typedef struct packed {
    mem_op_e                 op;
    logic [REG_ADDR_W-1:0]   rd;
  } mem_tag_t;

  localparam int unsigned TAG_W = $bits(mem_tag_t);

  // Stores are answered by the cache but produce nothing; loads to x0 are dropped.
  function automatic logic needs_writeback(input mem_tag_t tag);
    return (tag.op == MEM_OP_LOAD) && (tag.rd != '0);
  endfunction

endpackage

// File: rtl/mem_tag_fifo.sv
// Small synchronous FIFO holding the tags of requests that await a response.
// Parameters:
//   DEPTH : number of entries (1..8 in this design)
//   WIDTH : entry width in bits
// Ports:
//   clk, reset        : clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i: write one entry (ignored when full)
//   pop_i             : remove the head entry (ignored when empty)
//   pop_data_o        : current head entry
//   full_o/empty_o    : occupancy flags
// Push and pop in the same cycle are legal and leave the count unchanged.
module mem_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers wrap explicitly so non-power-of-two depths work.
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Load/store initiator between a pipeline command port and a cache.
// Accepts commands, issues them through a single request register, remembers
// {op, rd} of every outstanding request in an in-order tag FIFO, and turns
// load responses into one-cycle register-file writes.
// Parameter:
//   MAX_OUTSTANDING : commands accepted but not yet answered (1..8)
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_op/cmd_addr/cmd_wdata/cmd_rd : command payload (op 0 load, 1 store)
//   req_valid/req_ready              : cache request handshake
//   req_addr/req_op/req_wdata        : cache request payload
//   resp_valid/resp_ready/resp_data  : cache response (in order, one per request)
//   wb_en/wb_addr/wb_data            : regfile write port, no backpressure
//   busy                             : request pending or responses outstanding
//   err                              : misaligned-command pulse (see below)
// Build option:
//   MEM_INITIATOR_ALIGN_CHECK_EN : commands with addr[1:0] != 0 are accepted
//   but dropped, and err pulses the cycle after acceptance. Without it err is
//   tied low and addresses pass through unmodified.
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [XLEN-1:0]       cmd_addr,
  input  logic [XLEN-1:0]       cmd_wdata,
  input  logic [REG_ADDR_W-1:0] cmd_rd,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [XLEN-1:0]       req_addr,
  output logic                  req_op,
  output logic [XLEN-1:0]       req_wdata,
  input  logic                  resp_valid,
  output logic                  resp_ready,
  input  logic [XLEN-1:0]       resp_data,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  output logic                  busy,
  output logic                  err
);

  logic                  req_valid_q, req_valid_d;
  logic [XLEN-1:0]       req_addr_q,  req_addr_d;
  mem_op_e               req_op_q,    req_op_d;
  logic [XLEN-1:0]       req_wdata_q, req_wdata_d;

  logic                  wb_en_q,   wb_en_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  cmd_fire;
  logic                  issue;
  logic                  resp_fire;
  mem_tag_t              push_tag;
  mem_tag_t              head_tag;
  logic [TAG_W-1:0]      head_bits;

  // Both handshakes are held off while reset is asserted; the FIFO only
  // empties at the first reset edge, so its flags alone are not enough.
  assign cmd_ready  = ~reset & ~fifo_full & (~req_valid_q | req_ready);
  assign resp_ready = ~reset & ~fifo_empty;
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign resp_fire  = resp_valid & resp_ready;

`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
  logic misaligned;
  logic err_q, err_d;

  assign misaligned = (cmd_addr[1:0] != 2'b00);
  assign issue      = cmd_fire & ~misaligned;
  assign err_d      = cmd_fire & misaligned;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign issue = cmd_fire;
  assign err   = 1'b0;
`endif

  assign push_tag = '{op: mem_op_e'(cmd_op), rd: cmd_rd};
  assign head_tag = mem_tag_t'(head_bits);

  mem_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (issue),
    .push_data_i (push_tag),
    .pop_i       (resp_fire),
    .pop_data_o  (head_bits),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Request register: a new command may replace the one being handed off in
  // the same cycle, giving one request per cycle under a ready cache.
  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_op_d    = req_op_q;
    req_wdata_d = req_wdata_q;
    if (issue) begin
      req_valid_d = 1'b1;
      req_addr_d  = cmd_addr;
      req_op_d    = mem_op_e'(cmd_op);
      req_wdata_d = cmd_wdata;
    end else if (req_ready) begin
      req_valid_d = 1'b0;
    end
  end

  // Writeback: address/data only move when a write is actually produced.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (resp_fire && needs_writeback(head_tag)) begin
      wb_en_d   = 1'b1;
      wb_addr_d = head_tag.rd;
      wb_data_d = resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_op_q    <= MEM_OP_LOAD;
      req_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_op_q    <= req_op_d;
      req_wdata_q <= req_wdata_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;
  assign req_op    = req_op_q;
  assign req_wdata = req_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign busy      = req_valid_q | ~fifo_empty;

endmodule

// File: tb/tb_mem_initiator.sv
// Testbench for mem_initiator: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_mem_initiator;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [4:0]  cmd_rd;
  logic        req_valid, req_ready, req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_initiator #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_rd     (cmd_rd),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_op     (req_op),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid  = 1'b0;
    cmd_op     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_rd     = '0;
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    resp_data  = '0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Full zero-wait load: accept N, req N+1, resp N+2, wb_en visible in N+3.
  task automatic run_load(input string nm, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] data);
    @(negedge clk);
    idle_inputs();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = addr; cmd_rd = rd;
    #1 chk({nm, " accept cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1 chk({nm, " req_valid"}, 32'(req_valid), 32'd1);
    chk({nm, " req_addr"}, req_addr, addr);
    chk({nm, " err"}, 32'(err), 32'd0);
    @(negedge clk);
    resp_valid = 1'b1; resp_data = data;
    #1 chk({nm, " resp_ready"}, 32'(resp_ready), 32'd1);
    chk({nm, " early wb_en"}, 32'(wb_en), 32'd0);
    @(negedge clk);
    resp_valid = 1'b0;
    #1 chk({nm, " wb_en"}, 32'(wb_en), 32'd1);
    chk({nm, " wb_addr"}, 32'(wb_addr), 32'(rd));
    chk({nm, " wb_data"}, wb_data, data);
    @(negedge clk);
    #1 chk({nm, " wb_en one cycle"}, 32'(wb_en), 32'd0);
  endtask

  typedef struct {
    logic cv; logic op; logic [31:0] addr; logic [31:0] wd; logic [4:0] rd;
    logic rqr; logic rsv; logic [31:0] rsd;
    logic e_cr; logic e_rqv; logic [31:0] e_ra; logic e_rop; logic [31:0] e_rwd;
    logic e_rsr; logic e_wbe; logic [4:0] e_wba; logic [31:0] e_wbd; logic e_busy;
  } vec_t;

  vec_t vt[15];

  typedef struct { logic op; logic [4:0] rd; } mtag_t;

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acc;
    reset = 1'b1;
    idle_inputs();

    // ---------------- reset state ----------------
    cmd_valid = 1'b1; resp_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset resp_ready", 32'(resp_ready), 32'd0);
    chk("reset req_valid", 32'(req_valid), 32'd0);
    chk("reset wb_en", 32'(wb_en), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset req_addr", req_addr, 32'd0);
    chk("reset req_wdata", req_wdata, 32'd0);
    chk("reset req_op", 32'(req_op), 32'd0);
    chk("reset wb_addr", 32'(wb_addr), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();

    // ---------------- vector table ----------------
    // cv op addr wd rd | rqr rsv rsd | cr rqv ra rop rwd | rsr wbe wba wbd busy
    vt[0]  = '{1'b1,1'b0,32'h10,32'h0,5'd5,    1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,32'h0,    1'b0,1'b0,5'd0,32'h0,1'b0};
    vt[1]  = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b0,32'h0,         1'b1,1'b1,32'h10,1'b0,32'h0,   1'b1,1'b0,5'd0,32'h0,1'b1};
    vt[2]  = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b1,32'hDEADBEEF,  1'b1,1'b0,32'h0,1'b0,32'h0,    1'b1,1'b0,5'd0,32'h0,1'b1};
    vt[3]  = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,32'h0,    1'b0,1'b1,5'd5,32'hDEADBEEF,1'b0};
    vt[4]  = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,32'h0,    1'b0,1'b0,5'd5,32'hDEADBEEF,1'b0};
    vt[5]  = '{1'b1,1'b1,32'h20,32'h1234,5'd7, 1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,32'h0,    1'b0,1'b0,5'd5,32'hDEADBEEF,1'b0};
    vt[6]  = '{1'b1,1'b0,32'h20,32'h0,5'd3,    1'b1,1'b0,32'h0,         1'b1,1'b1,32'h20,1'b1,32'h1234,1'b1,1'b0,5'd5,32'hDEADBEEF,1'b1};
    vt[7]  = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b1,32'h0,         1'b0,1'b1,32'h20,1'b0,32'h0,   1'b1,1'b0,5'd5,32'hDEADBEEF,1'b1};
    vt[8]  = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b1,32'h1234,      1'b1,1'b0,32'h0,1'b0,32'h0,    1'b1,1'b0,5'd5,32'hDEADBEEF,1'b1};
    vt[9]  = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,32'h0,    1'b0,1'b1,5'd3,32'h1234,1'b0};
    vt[10] = '{1'b1,1'b0,32'h8,32'h0,5'd0,     1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,32'h0,    1'b0,1'b0,5'd3,32'h1234,1'b0};
    vt[11] = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b0,32'h0,         1'b1,1'b1,32'h8,1'b0,32'h0,    1'b1,1'b0,5'd3,32'h1234,1'b1};
    vt[12] = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b1,32'hAAAA5555,  1'b1,1'b0,32'h0,1'b0,32'h0,    1'b1,1'b0,5'd3,32'h1234,1'b1};
    vt[13] = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,32'h0,    1'b0,1'b0,5'd3,32'h1234,1'b0};
    vt[14] = '{1'b0,1'b0,32'h0,32'h0,5'd0,     1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,1'b0,32'h0,    1'b0,1'b0,5'd3,32'h1234,1'b0};

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cmd_valid = vt[i].cv; cmd_op = vt[i].op; cmd_addr = vt[i].addr;
      cmd_wdata = vt[i].wd; cmd_rd = vt[i].rd; req_ready = vt[i].rqr;
      resp_valid = vt[i].rsv; resp_data = vt[i].rsd;
      #1;
      chk($sformatf("vec%0d cmd_ready", i), 32'(cmd_ready), 32'(vt[i].e_cr));
      chk($sformatf("vec%0d req_valid", i), 32'(req_valid), 32'(vt[i].e_rqv));
      chk($sformatf("vec%0d resp_ready", i), 32'(resp_ready), 32'(vt[i].e_rsr));
      chk($sformatf("vec%0d wb_en", i), 32'(wb_en), 32'(vt[i].e_wbe));
      chk($sformatf("vec%0d wb_addr", i), 32'(wb_addr), 32'(vt[i].e_wba));
      chk($sformatf("vec%0d wb_data", i), wb_data, vt[i].e_wbd);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
      if (vt[i].e_rqv) begin
        chk($sformatf("vec%0d req_addr", i), req_addr, vt[i].e_ra);
        chk($sformatf("vec%0d req_op", i), 32'(req_op), 32'(vt[i].e_rop));
        chk($sformatf("vec%0d req_wdata", i), req_wdata, vt[i].e_rwd);
      end
    end

    // ---------------- backpressure ----------------
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle_inputs();
      cmd_valid = 1'b1; cmd_op = 1'b1;
      cmd_addr = 32'h100 + 32'(c * 4); cmd_wdata = 32'(c);
      req_ready = (c >= 5);
      #1;
      if (cmd_ready) acc++;
      if (c >= 1 && c <= 4) begin
        chk($sformatf("bp stall%0d req_valid", c), 32'(req_valid), 32'd1);
        chk($sformatf("bp stall%0d req_addr stable", c), req_addr, 32'h100);
        chk($sformatf("bp stall%0d cmd_ready", c), 32'(cmd_ready), 32'd0);
      end
      if (c == 5) chk("bp release cmd_ready", 32'(cmd_ready), 32'd1);
      if (c >= 6) chk($sformatf("bp full%0d cmd_ready", c), 32'(cmd_ready), 32'd0);
      if (c == 6) chk("bp second req_addr", req_addr, 32'h114);
    end
    chk("bp accepted total", 32'(acc), 32'(MAXO));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_inputs();
      resp_valid = 1'b1; resp_data = 32'hFFFF0000;
      #1;
      chk($sformatf("bp drain%0d resp_ready", k), 32'(resp_ready), 32'(k < 2));
      chk($sformatf("bp drain%0d busy", k), 32'(busy), 32'(k < 2));
      chk($sformatf("bp drain%0d wb_en", k), 32'(wb_en), 32'd0);
    end

    // ---------------- reset with loads outstanding ----------------
    @(negedge clk);
    idle_inputs();
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_rd = 5'd9;
    @(negedge clk);
    cmd_addr = 32'h44; cmd_rd = 5'd10;
    #1 chk("rst-mid second accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b1; resp_valid = 1'b1; resp_data = 32'h55;
    #1;
    chk("rst-mid busy before", 32'(busy), 32'd1);
    chk("rst-mid cmd_ready in reset", 32'(cmd_ready), 32'd0);
    chk("rst-mid resp_ready in reset", 32'(resp_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rst-mid busy cleared", 32'(busy), 32'd0);
    chk("rst-mid req_valid cleared", 32'(req_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst-mid after%0d wb_en", k), 32'(wb_en), 32'd0);
      chk($sformatf("rst-mid after%0d resp_ready", k), 32'(resp_ready), 32'd0);
      chk($sformatf("rst-mid after%0d busy", k), 32'(busy), 32'd0);
    end
    run_load("rst-mid next load", 32'h80, 5'd12, 32'hCAFEF00D);

    // ---------------- misaligned address ----------------
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
    @(negedge clk);
    idle_inputs();
    cmd_valid = 1'b1; cmd_addr = 32'h6; cmd_rd = 5'd4;
    #1 chk("align accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("align err pulse", 32'(err), 32'd1);
    chk("align req_valid", 32'(req_valid), 32'd0);
    chk("align busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("align err one cycle", 32'(err), 32'd0);
    chk("align no wb_en", 32'(wb_en), 32'd0);
    chk("align no resp_ready", 32'(resp_ready), 32'd0);
`else
    run_load("unaligned passthrough", 32'h6, 5'd4, 32'h01020304);
`endif

    // ---------------- randomized run vs model ----------------
    apply_reset(2);
    begin
      mtag_t       tq[$];
      mtag_t       t;
      logic        m_rv, m_rop, m_wbe, m_err, m_cr, m_rsr, acc_c, pop_c, mis;
      logic [31:0] m_ra, m_rwd, m_wbd;
      logic [4:0]  m_wba;
      int          pend;
      m_rv = 0; m_rop = 0; m_ra = '0; m_rwd = '0;
      m_wbe = 0; m_wba = '0; m_wbd = '0; m_err = 0; pend = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(negedge clk);
        cmd_valid = ($urandom_range(0, 9) < 6);
        cmd_op    = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        if ($urandom_range(0, 3) != 0) cmd_addr[1:0] = 2'b00;
        cmd_wdata = $urandom;
        cmd_rd    = 5'($urandom_range(0, 31));
        req_ready = ($urandom_range(0, 3) != 0);
        resp_valid = (pend > 0 || tq.size() == 0) ? ($urandom_range(0, 9) < 6) : 1'b0;
        resp_data = $urandom;
        #1;
        m_cr  = (tq.size() < MAXO) && (!m_rv || req_ready);
        m_rsr = (tq.size() != 0);
        chk($sformatf("rnd%0d cmd_ready", cyc), 32'(cmd_ready), 32'(m_cr));
        chk($sformatf("rnd%0d resp_ready", cyc), 32'(resp_ready), 32'(m_rsr));
        chk($sformatf("rnd%0d req_valid", cyc), 32'(req_valid), 32'(m_rv));
        chk($sformatf("rnd%0d busy", cyc), 32'(busy), 32'(m_rv || tq.size() != 0));
        chk($sformatf("rnd%0d wb_en", cyc), 32'(wb_en), 32'(m_wbe));
        chk($sformatf("rnd%0d wb_addr", cyc), 32'(wb_addr), 32'(m_wba));
        chk($sformatf("rnd%0d wb_data", cyc), wb_data, m_wbd);
        chk($sformatf("rnd%0d err", cyc), 32'(err), 32'(m_err));
        if (m_rv) begin
          chk($sformatf("rnd%0d req_addr", cyc), req_addr, m_ra);
          chk($sformatf("rnd%0d req_op", cyc), 32'(req_op), 32'(m_rop));
          chk($sformatf("rnd%0d req_wdata", cyc), req_wdata, m_rwd);
        end
        acc_c = cmd_valid && m_cr;
        pop_c = resp_valid && m_rsr;
        mis   = 1'b0;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
        mis   = (cmd_addr[1:0] != 2'b00);
`endif
        if (m_rv && req_ready) pend++;
        m_wbe = 1'b0;
        if (pop_c) begin
          t = tq.pop_front();
          pend--;
          if (t.op == 1'b0 && t.rd != 5'd0) begin
            m_wbe = 1'b1; m_wba = t.rd; m_wbd = resp_data;
          end
        end
        m_err = acc_c && mis;
        if (acc_c && !mis) begin
          m_rv = 1'b1; m_ra = cmd_addr; m_rop = cmd_op; m_rwd = cmd_wdata;
          tq.push_back('{op: cmd_op, rd: cmd_rd});
        end else if (req_ready) begin
          m_rv = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
